piso_serializer: RTL and testbench

- Parametrised parallel-in serial-out shift register, the successor to the fixed 8-bit PISO.
- Adds configurable word width and bit order, a valid/ready load handshake, and a downstream shift-enable for stalls.
- Adds frame framing (busy/last) and gap-free back-to-back words.
- Sits between a parallel word source and a bit-serial link or transmitter.

---
 rtl/piso_serializer.sv | 97 +++++++++
 tb/tb_piso_serializer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/piso_serializer.sv
// piso_serializer: parametrised parallel-in serial-out shift register.
// Accepts a WIDTH-bit word over a valid/ready handshake and presents it one
// bit at a time, advancing only when the downstream asserts shift_en. The
// final consume of a word can coincide with the load of the next one, so
// words stream back-to-back with no idle bit between them.
module piso_serializer #(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b0,
  parameter int CNT_W     = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] data_in,
  input  logic             shift_en,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             last,
  output logic             busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] shift_next;
  logic [WIDTH-1:0] shifted;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  logic             accept;
  logic             consume;

  // Status outputs and handshake: all combinational from state, count and shift_en.
  assign busy         = (state == SHIFT);
  assign serial_valid = (state == SHIFT);
  assign last         = (state == SHIFT) && (count == LAST_CNT);
  assign load_ready   = (state == IDLE) || (last && shift_en);
  assign accept       = load_valid && load_ready;
  assign consume      = (state == SHIFT) && shift_en;

  // Output bit taken straight from the output end of the shift register.
  always_comb begin
    serial_out = 1'b0;
    if (state == SHIFT) begin
      if (LSB_FIRST) serial_out = shift_reg[0];
      else           serial_out = shift_reg[WIDTH-1];
    end
  end

  // Shift toward the output end, zero-filling the vacated position.
  always_comb begin
    shifted = '0;
    if (LSB_FIRST) shifted = {1'b0, shift_reg[WIDTH-1:1]};
    else           shifted = {shift_reg[WIDTH-2:0], 1'b0};
  end

  // Next-state logic: a new load wins over the final consume it coincides with.
  always_comb begin
    state_next = state;
    shift_next = shift_reg;
    count_next = count;
    if (accept) begin
      state_next = SHIFT;
      shift_next = data_in;
      count_next = '0;
    end else if (consume) begin
      shift_next = shifted;
      if (last) begin
        state_next = IDLE;
        count_next = '0;
      end else begin
        count_next = count + 1'b1;
      end
    end
  end

  // State, shift register and bit counter, all cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      shift_reg <= '0;
      count     <= '0;
    end else begin
      state     <= state_next;
      shift_reg <= shift_next;
      count     <= count_next;
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: bench for piso_serializer with three instances
// (8-bit MSB-first, 8-bit LSB-first, 16-bit MSB-first). Expected bit streams
// come from literal patterns; every consumed bit is matched against a queue.
module tb_piso_serializer;

  logic        clk = 1'b0;
  logic        reset;
  logic        lv  [3];
  logic        sen [3];
  logic [15:0] d   [3];
  logic        so  [3];
  logic        sv  [3];
  logic        lst [3];
  logic        bsy [3];
  logic        lr  [3];

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(8), .LSB_FIRST(1'b0)) u_msb8 (
    .clk(clk), .reset(reset), .load_valid(lv[0]), .load_ready(lr[0]),
    .data_in(d[0][7:0]), .shift_en(sen[0]), .serial_out(so[0]),
    .serial_valid(sv[0]), .last(lst[0]), .busy(bsy[0])
  );

  piso_serializer #(.WIDTH(8), .LSB_FIRST(1'b1)) u_lsb8 (
    .clk(clk), .reset(reset), .load_valid(lv[1]), .load_ready(lr[1]),
    .data_in(d[1][7:0]), .shift_en(sen[1]), .serial_out(so[1]),
    .serial_valid(sv[1]), .last(lst[1]), .busy(bsy[1])
  );

  piso_serializer #(.WIDTH(16), .LSB_FIRST(1'b0)) u_msb16 (
    .clk(clk), .reset(reset), .load_valid(lv[2]), .load_ready(lr[2]),
    .data_in(d[2]), .shift_en(sen[2]), .serial_out(so[2]),
    .serial_valid(sv[2]), .last(lst[2]), .busy(bsy[2])
  );

  typedef struct {
    int   sel;
    logic b;
    logic l;
  } sb_t;

  typedef struct {
    int          sel;
    logic [15:0] data;
    logic [15:0] pat;
    int          n;
    int          stall_at;
  } vec_t;

  sb_t  sb [$];
  vec_t vecs [6];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic act, input logic expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, expv, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  // Sampled on the falling edge: any bit shown with shift_en high is consumed
  // at the coming rising edge and must match the head of the queue.
  task automatic mon();
    sb_t e;
    for (int i = 0; i < 3; i++) begin
      if (!reset) begin
        if (!bsy[i]) chk("idle_serial_out", so[i], 1'b0);
        if (sv[i] && sen[i]) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_underflow: dut %0d got bit %b expected none", i, so[i]);
          end else begin
            e = sb.pop_front();
            chk_int("sb_sel", i, e.sel);
            chk("sb_bit", so[i], e.b);
            chk("sb_last", lst[i], e.l);
          end
        end
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    mon();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input int sel, input logic [15:0] pat, input int n);
    sb_t e;
    for (int k = 0; k < n; k++) begin
      e.sel = sel;
      e.b   = pat[n-1-k];
      e.l   = (k == n - 1);
      sb.push_back(e);
    end
  endtask

  task automatic chk_idle(input int sel);
    chk("idle_busy", bsy[sel], 1'b0);
    chk("idle_out", so[sel], 1'b0);
    chk("idle_valid", sv[sel], 1'b0);
    chk("idle_last", lst[sel], 1'b0);
    chk("idle_ready", lr[sel], 1'b1);
  endtask

  task automatic send_word(input int sel, input logic [15:0] data,
                           input logic [15:0] pat, input int n, input int stall_at);
    lv[sel] = 1'b1;
    d[sel]  = data;
    push_word(sel, pat, n);
    step();
    lv[sel] = 1'b0;
    for (int k = 0; k < n; k++) begin
      chk("busy", bsy[sel], 1'b1);
      chk("last", lst[sel], k == n - 1);
      chk("load_ready", lr[sel], k == n - 1);
      chk("bit", so[sel], pat[n-1-k]);
      if (k == stall_at) begin
        sen[sel] = 1'b0;
        repeat (3) begin
          step();
          chk("stall_bit", so[sel], pat[n-1-k]);
          chk("stall_last", lst[sel], k == n - 1);
          chk("stall_ready", lr[sel], 1'b0);
        end
        sen[sel] = 1'b1;
      end
      step();
    end
    chk_idle(sel);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{0, 16'h001E, 16'h001E,  8, -1};
    vecs[1] = '{1, 16'h001E, 16'h0078,  8, -1};
    vecs[2] = '{0, 16'h00F0, 16'h00F0,  8,  1};
    vecs[3] = '{2, 16'h8001, 16'h8001, 16, -1};
    vecs[4] = '{1, 16'h0080, 16'h0001,  8,  3};
    vecs[5] = '{0, 16'h00A5, 16'h00A5,  8, -1};

    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      lv[i]  = 1'b0;
      sen[i] = 1'b1;
      d[i]   = 16'h0;
    end
    step();
    step();
    for (int i = 0; i < 3; i++) chk_idle(i);
    reset = 1'b0;
    step();

    for (int v = 0; v < 6; v++) begin
      send_word(vecs[v].sel, vecs[v].data, vecs[v].pat, vecs[v].n, vecs[v].stall_at);
      step();
    end

    // Back-to-back: second word offered during the final bit of the first.
    lv[0] = 1'b1;
    d[0]  = 16'h001E;
    push_word(0, 16'h001E, 8);
    step();
    lv[0] = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk("b2b_valid_a", sv[0], 1'b1);
      chk("b2b_last_a", lst[0], k == 7);
      if (k == 7) begin
        lv[0] = 1'b1;
        d[0]  = 16'h00F0;
        push_word(0, 16'h00F0, 8);
        chk("b2b_ready", lr[0], 1'b1);
      end
      step();
      if (k == 7) lv[0] = 1'b0;
    end
    for (int k = 0; k < 8; k++) begin
      chk("b2b_valid_b", sv[0], 1'b1);
      chk("b2b_last_b", lst[0], k == 7);
      step();
    end
    chk_idle(0);
    step();

    // Ignored load while busy: 0xFF must not disturb 0x1E.
    lv[0] = 1'b1;
    d[0]  = 16'h001E;
    push_word(0, 16'h001E, 8);
    step();
    lv[0] = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (k == 2) begin
        lv[0] = 1'b1;
        d[0]  = 16'h00FF;
        chk("ignored_ready", lr[0], 1'b0);
      end
      step();
      if (k == 2) lv[0] = 1'b0;
    end
    chk_idle(0);
    step();

    // Reset while the fourth bit of 0x1E is on the line.
    lv[0] = 1'b1;
    d[0]  = 16'h001E;
    push_word(0, 16'h001E, 8);
    step();
    lv[0] = 1'b0;
    repeat (3) step();
    chk("pre_reset_bit4", so[0], 1'b1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    sb.delete();
    chk_idle(0);
    step();
    send_word(0, 16'h00F0, 16'h00F0, 8, -1);
    step();

    chk_int("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
